vga_sync_gen: RTL and testbench

Generates VGA raster timing: horizontal/vertical pixel counters, active-low sync pulses, and a display-enable flag. Its x/y outputs drive the pixel-colour stages, including rectangle overlays and other shape generators, whose R/G/B outputs the top level gates with video_on. Pixel rate is derived from the system clock by a clock-enable divider; no generated clocks.

---
 rtl/vga_sync_gen.sv | 93 +++++++++
 tb/tb_vga_sync_gen.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing (counters, active-low syncs, display enable) driven by a clock-enable pixel divider.
// Optional macro VGA_SYNC_FRAME_CNT_EN adds a 16-bit frame_count output.
module vga_sync_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        p_tick,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    output logic [15:0] frame_count
`endif
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [9:0] H_MAX    = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_MAX    = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [DW-1:0] div_q, div_d;
    logic [9:0]    x_q, x_d, y_q, y_d;
    logic          hsync_q, vsync_q, video_on_q, frame_start_q;
    logic          line_end, frame_end;

    assign p_tick      = div_q == DIV_MAX;
    assign x           = x_q;
    assign y           = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign frame_start = frame_start_q;

    // Next-state: divider wraps every pixel, x advances on p_tick, y advances when x wraps
    always_comb begin
        line_end  = p_tick && x_q == H_MAX;
        frame_end = line_end && y_q == V_MAX;
        div_d     = p_tick ? '0 : div_q + 1'b1;
        x_d       = line_end ? '0 : p_tick ? x_q + 10'd1 : x_q;
        y_d       = frame_end ? '0 : line_end ? y_q + 10'd1 : y_q;
    end

    // State registers; decodes use next-state counts so they line up with x/y in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= !(x_d >= HS_START && x_d < HS_END);
            vsync_q       <= !(y_d >= VS_START && y_d < VS_END);
            video_on_q    <= x_d < H_VIS && y_d < V_VIS;
            frame_start_q <= frame_end;
        end
    end

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [15:0] frame_count_q;

    assign frame_count = frame_count_q;

    // Frame counter steps on the same edge that raises frame_start, wrapping naturally at 16 bits
    always_ff @(posedge clk) begin
        if (reset) frame_count_q <= '0;
        else if (frame_end) frame_count_q <= frame_count_q + 16'd1;
    end
`endif
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed bench for vga_sync_gen using a full-size CLK_DIV=4 instance, a full-size CLK_DIV=1 instance and a tiny-raster CLK_DIV=2 instance.
module tb_vga_sync_gen;
    logic clk = 1'b0;
    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    logic pt_a, hs_a, vs_a, vo_a, fs_a;
    logic pt_b, hs_b, vs_b, vo_b, fs_b;
    logic pt_c, hs_c, vs_c, vo_c, fs_c;
    logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c;
`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [15:0] fc_a, fc_b, fc_c;
    logic [15:0] fc_at [1:3];
`endif
    int checks = 0, errors = 0;
    int prev, seq_err, hs_cnt, hs_min, hs_max, vo_cnt, vo_min, vs_low, wrap_y, pt_low, x_799;
    int pulses, width_err, xy_err, vs_cnt, vs_min, vs_max, found;
    int pulse_t [1:3];
    logic fs_prev;

    vga_sync_gen u_a (
        .clk(clk), .reset(rst_a), .p_tick(pt_a), .x(x_a), .y(y_a),
        .hsync(hs_a), .vsync(vs_a), .video_on(vo_a), .frame_start(fs_a)
`ifdef VGA_SYNC_FRAME_CNT_EN
        , .frame_count(fc_a)
`endif
    );

    vga_sync_gen #(.CLK_DIV(1)) u_b (
        .clk(clk), .reset(rst_b), .p_tick(pt_b), .x(x_b), .y(y_b),
        .hsync(hs_b), .vsync(vs_b), .video_on(vo_b), .frame_start(fs_b)
`ifdef VGA_SYNC_FRAME_CNT_EN
        , .frame_count(fc_b)
`endif
    );

    vga_sync_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .CLK_DIV(2)
    ) u_c (
        .clk(clk), .reset(rst_c), .p_tick(pt_c), .x(x_c), .y(y_c),
        .hsync(hs_c), .vsync(vs_c), .video_on(vo_c), .frame_start(fs_c)
`ifdef VGA_SYNC_FRAME_CNT_EN
        , .frame_count(fc_c)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        repeat (3) tick;
        check("a_rst_x", 32'(x_a), 0);
        check("a_rst_y", 32'(y_a), 0);
        check("a_rst_hsync", 32'(hs_a), 1);
        check("a_rst_vsync", 32'(vs_a), 1);
        check("a_rst_video_on", 32'(vo_a), 1);
        check("a_rst_frame_start", 32'(fs_a), 0);
        check("a_rst_p_tick", 32'(pt_a), 0);
        rst_a = 1'b0;
        tick;
        tick;
        check("a_p_tick_early", 32'(pt_a), 0);
        tick;
        check("a_p_tick_first", 32'(pt_a), 1);
        check("a_x_at_first_tick", 32'(x_a), 0);
        tick;
        check("a_x_after_first_tick", 32'(x_a), 1);
        check("a_p_tick_after", 32'(pt_a), 0);
        prev = 1; seq_err = 0; hs_cnt = 0; hs_min = 1023; hs_max = 0;
        vo_cnt = 0; vo_min = 1023; vs_low = 0; wrap_y = -1;
        for (int i = 0; i < 800; i++) begin
            repeat (4) tick;
            if (int'(x_a) != (prev == 799 ? 0 : prev + 1)) seq_err++;
            prev = int'(x_a);
            if (!hs_a) begin
                hs_cnt++;
                if (int'(x_a) < hs_min) hs_min = int'(x_a);
                if (int'(x_a) > hs_max) hs_max = int'(x_a);
            end
            if (!vo_a) begin
                vo_cnt++;
                if (int'(x_a) < vo_min) vo_min = int'(x_a);
            end
            if (!vs_a) vs_low++;
            if (x_a == 10'd0) wrap_y = int'(y_a);
        end
        check("a_x_sequence_errors", 32'(seq_err), 0);
        check("a_hsync_low_pixels", 32'(hs_cnt), 96);
        check("a_hsync_first_x", 32'(hs_min), 656);
        check("a_hsync_last_x", 32'(hs_max), 751);
        check("a_video_off_pixels", 32'(vo_cnt), 160);
        check("a_video_off_first_x", 32'(vo_min), 640);
        check("a_vsync_low_in_line0", 32'(vs_low), 0);
        check("a_y_after_wrap", 32'(wrap_y), 1);

        rst_b = 1'b0;
        pt_low = 0; x_799 = -1;
        for (int i = 1; i <= 800; i++) begin
            tick;
            if (!pt_b) pt_low++;
            if (i == 799) x_799 = int'(x_b);
        end
        check("b_p_tick_low_count", 32'(pt_low), 0);
        check("b_x_at_799", 32'(x_799), 799);
        check("b_x_line_wrap", 32'(x_b), 0);
        check("b_y_line_wrap", 32'(y_b), 1);
        check("b_hsync_after_wrap", 32'(hs_b), 1);
        check("b_vsync_after_wrap", 32'(vs_b), 1);
        check("b_video_on_after_wrap", 32'(vo_b), 1);
        check("b_frame_start_line", 32'(fs_b), 0);
`ifdef VGA_SYNC_FRAME_CNT_EN
        check("a_frame_count_no_frame", 32'(fc_a), 0);
        check("b_frame_count_no_frame", 32'(fc_b), 0);
        check("c_frame_count_reset", 32'(fc_c), 0);
`endif

        rst_c = 1'b0;
        pulses = 0; width_err = 0; xy_err = 0; vs_cnt = 0; vs_min = 1023; vs_max = 0;
        fs_prev = 1'b0;
        for (int k = 1; k <= 3; k++) pulse_t[k] = -1;
        for (int t = 1; t <= 720; t++) begin
            tick;
            if (fs_c) begin
                if (fs_prev) width_err++;
                else begin
                    pulses++;
                    if (pulses <= 3) begin
                        pulse_t[pulses] = t;
`ifdef VGA_SYNC_FRAME_CNT_EN
                        fc_at[pulses] = fc_c;
`endif
                    end
                end
                if (x_c != 10'd0 || y_c != 10'd0) xy_err++;
            end
            fs_prev = fs_c;
            if (t <= 240 && pt_c && !vs_c) begin
                vs_cnt++;
                if (int'(y_c) < vs_min) vs_min = int'(y_c);
                if (int'(y_c) > vs_max) vs_max = int'(y_c);
            end
        end
        check("c_frame_pulses", 32'(pulses), 3);
        check("c_pulse1_time", 32'(pulse_t[1]), 240);
        check("c_pulse2_time", 32'(pulse_t[2]), 480);
        check("c_pulse3_time", 32'(pulse_t[3]), 720);
        check("c_pulse_width_errors", 32'(width_err), 0);
        check("c_pulse_xy_errors", 32'(xy_err), 0);
        check("c_vsync_low_pixels", 32'(vs_cnt), 30);
        check("c_vsync_first_y", 32'(vs_min), 5);
        check("c_vsync_last_y", 32'(vs_max), 6);
`ifdef VGA_SYNC_FRAME_CNT_EN
        check("c_frame_count_1", 32'(fc_at[1]), 1);
        check("c_frame_count_2", 32'(fc_at[2]), 2);
        check("c_frame_count_3", 32'(fc_at[3]), 3);
`endif

        found = 0;
        for (int t = 0; t < 400 && found == 0; t++) begin
            tick;
            if (x_c == 10'd11 && y_c == 10'd5) found = 1;
        end
        check("c_reached_x11_y5", 32'(found), 1);
        check("c_hsync_before_reset", 32'(hs_c), 0);
        check("c_vsync_before_reset", 32'(vs_c), 0);
        rst_c = 1'b1;
        tick;
        check("c_midreset_x", 32'(x_c), 0);
        check("c_midreset_y", 32'(y_c), 0);
        check("c_midreset_hsync", 32'(hs_c), 1);
        check("c_midreset_vsync", 32'(vs_c), 1);
        check("c_midreset_video_on", 32'(vo_c), 1);
        check("c_midreset_frame_start", 32'(fs_c), 0);
        check("c_midreset_p_tick", 32'(pt_c), 0);
`ifdef VGA_SYNC_FRAME_CNT_EN
        check("c_midreset_frame_count", 32'(fc_c), 0);
`endif
        rst_c = 1'b0;
        tick;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
